// File: rtl/picosoc_bus_arbiter.sv
// Two-master (CPU=m0, DMA=m1) to one-slave arbiter with a per-transfer wait timeout.
// Define ARB_ROUND_ROBIN_EN to alternate masters on simultaneous requests; default is fixed m0 priority.
module picosoc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [15:0] TIMEOUT_VAL = TIMEOUT_CYCLES[15:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [15:0] r_wait_cnt;

  logic        w_active;
  logic        w_sel_m1;
  logic        w_m_valid;
  logic        w_m_instr;
  logic [31:0] w_m_addr;
  logic [31:0] w_m_wdata;
  logic [3:0]  w_m_wstrb;
  logic        w_done;
  logic        w_timeout;
  logic        w_pick_m1;

  assign w_active  = (r_state != IDLE);
  assign w_sel_m1  = (r_state == G1);
  assign w_m_valid = w_sel_m1 ? m1_valid : m0_valid;
  assign w_m_instr = w_sel_m1 ? m1_instr : m0_instr;
  assign w_m_addr  = w_sel_m1 ? m1_addr  : m0_addr;
  assign w_m_wdata = w_sel_m1 ? m1_wdata : m0_wdata;
  assign w_m_wstrb = w_sel_m1 ? m1_wstrb : m0_wstrb;

  assign w_done    = w_active && w_m_valid && s_ready;
  // A slave response in the expiry cycle wins over the timeout.
  assign w_timeout = w_active && (TIMEOUT_VAL != 16'd0) && w_m_valid && !s_ready
                     && (r_wait_cnt == TIMEOUT_VAL);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_m1 = m1_valid && (!m0_valid || !r_last_grant);
`else
  assign w_pick_m1 = m1_valid && !m0_valid;
`endif

  always_comb begin
    s_valid     = w_active && w_m_valid && !w_timeout;
    s_instr     = w_active && w_m_instr;
    s_addr      = w_active ? w_m_addr  : 32'h0;
    s_wdata     = w_active ? w_m_wdata : 32'h0;
    s_wstrb     = w_active ? w_m_wstrb : 4'h0;
    m0_ready    = (r_state == G0) && (s_ready || w_timeout);
    m1_ready    = (r_state == G1) && (s_ready || w_timeout);
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    if (r_state == G0) m0_rdata = w_timeout ? 32'hFFFF_FFFF : s_rdata;
    if (r_state == G1) m1_rdata = w_timeout ? 32'hFFFF_FFFF : s_rdata;
    grant       = {r_state == G1, r_state == G0};
    timeout_err = w_timeout;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            r_state    <= w_pick_m1 ? G1 : G0;
            r_wait_cnt <= 16'd0;
          end
        end
        G0, G1: begin
          if (w_done || w_timeout) begin
            r_state      <= IDLE;
            r_last_grant <= w_sel_m1;
          end else if (!w_m_valid) begin
            // Master withdrew its request mid-transfer: abandon quietly.
            r_state <= IDLE;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: vector table, hand-written timeout/reset sequences, random vs. model.
module tb_picosoc_bus_arbiter;

  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  picosoc_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive(input bit v0, input bit v1, input bit sr, input logic [31:0] rd);
    @(negedge clk);
    m0_valid = v0; m1_valid = v1; s_ready = sr; s_rdata = rd;
    #1;
  endtask

  typedef struct {
    bit          m0v, m1v, srdy;
    logic [31:0] srdata;
    logic [1:0]  grant;
    bit          svalid;
    logic [31:0] saddr, swdata;
    bit          m0rdy, m1rdy;
    logic [31:0] m0rd, m1rd;
    bit          to;
  } vec_t;

  function automatic vec_t mk(bit v0, bit v1, bit sr, logic [31:0] rd, logic [1:0] g, bit sv,
                              logic [31:0] sa, logic [31:0] sw, bit r0, bit r1,
                              logic [31:0] d0, logic [31:0] d1);
    vec_t v;
    v.m0v = v0; v.m1v = v1; v.srdy = sr; v.srdata = rd; v.grant = g; v.svalid = sv;
    v.saddr = sa; v.swdata = sw; v.m0rdy = r0; v.m1rdy = r1; v.m0rd = d0; v.m1rd = d1;
    v.to = 1'b0;
    return v;
  endfunction

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0300_0000;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;

  vec_t tbl[17];

  // reference model state (owner: 0 none, 1 = m0, 2 = m1)
  int owner, waited, last;

  initial begin
    tbl[0]  = mk(1,0,0,32'h0,         2'b00,0,0, 0, 0,0,0,0);
    tbl[1]  = mk(1,0,0,32'hDEAD_BEEF, 2'b01,1,A0,0, 0,0,32'hDEAD_BEEF,0);
    tbl[2]  = mk(1,0,1,32'h1234_5678, 2'b01,1,A0,0, 1,0,32'h1234_5678,0);
    tbl[3]  = mk(0,0,0,32'h0,         2'b00,0,0, 0, 0,0,0,0);
    tbl[4]  = mk(0,1,0,32'h0,         2'b00,0,0, 0, 0,0,0,0);
    tbl[5]  = mk(0,1,0,32'h0,         2'b10,1,A1,W1,0,0,0,0);
    tbl[6]  = mk(0,1,1,32'h0,         2'b10,1,A1,W1,0,1,0,0);
    tbl[7]  = mk(0,0,0,32'h0,         2'b00,0,0, 0, 0,0,0,0);
    tbl[8]  = mk(1,1,1,32'hA5A5_0008, 2'b00,0,0, 0, 0,0,0,0);
    tbl[9]  = mk(1,1,1,32'hA5A5_0009, 2'b01,1,A0,0, 1,0,32'hA5A5_0009,0);
    tbl[10] = mk(1,1,1,32'hA5A5_000A, 2'b00,0,0, 0, 0,0,0,0);
    tbl[11] = RR ? mk(1,1,1,32'hA5A5_000B, 2'b10,1,A1,W1,0,1,0,32'hA5A5_000B)
                 : mk(1,1,1,32'hA5A5_000B, 2'b01,1,A0,0, 1,0,32'hA5A5_000B,0);
    tbl[12] = mk(1,1,1,32'hA5A5_000C, 2'b00,0,0, 0, 0,0,0,0);
    tbl[13] = mk(1,1,1,32'hA5A5_000D, 2'b01,1,A0,0, 1,0,32'hA5A5_000D,0);
    tbl[14] = mk(1,1,1,32'hA5A5_000E, 2'b00,0,0, 0, 0,0,0,0);
    tbl[15] = RR ? mk(1,1,1,32'hA5A5_000F, 2'b10,1,A1,W1,0,1,0,32'hA5A5_000F)
                 : mk(1,1,1,32'hA5A5_000F, 2'b01,1,A0,0, 1,0,32'hA5A5_000F,0);
    tbl[16] = mk(0,0,0,32'h0,         2'b00,0,0, 0, 0,0,0,0);

    // reset state, sampled while reset is held
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chkb("rst_svalid", s_valid, 1'b0);
    chkb("rst_m0_ready", m0_ready, 1'b0);
    chkb("rst_m1_ready", m1_ready, 1'b0);
    chkb("rst_timeout", timeout_err, 1'b0);
    chk("rst_saddr", s_addr, 32'h0);
    do_reset();

    m0_instr = 0; m0_addr = A0; m0_wdata = 0;  m0_wstrb = 4'h0;
    m1_instr = 0; m1_addr = A1; m1_wdata = W1; m1_wstrb = 4'hF;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].m0v, tbl[i].m1v, tbl[i].srdy, tbl[i].srdata);
      $display("vec %0d: grant=%b s_valid=%b m0_ready=%b m1_ready=%b", i, grant, s_valid, m0_ready, m1_ready);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chkb($sformatf("vec%0d_svalid", i), s_valid, tbl[i].svalid);
      chk($sformatf("vec%0d_saddr", i), s_addr, tbl[i].saddr);
      chk($sformatf("vec%0d_swdata", i), s_wdata, tbl[i].swdata);
      chkb($sformatf("vec%0d_m0_ready", i), m0_ready, tbl[i].m0rdy);
      chkb($sformatf("vec%0d_m1_ready", i), m1_ready, tbl[i].m1rdy);
      chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, tbl[i].m0rd);
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].m1rd);
      chkb($sformatf("vec%0d_timeout", i), timeout_err, tbl[i].to);
    end

    // Timeout: slave never ready, pulse TO cycles after grant; then s_ready in expiry cycle wins.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      drive(1'b1, 1'b0, (c == 11), 32'h0BAD_CAFE);
      $display("timeout seq cycle %0d: grant=%b m0_ready=%b timeout_err=%b", c, grant, m0_ready, timeout_err);
      chk($sformatf("to%0d_grant", c), 32'(grant),
          (c == 0 || c == 6 || c == 12) ? 32'h0 : 32'h1);
      chkb($sformatf("to%0d_timeout", c), timeout_err, (c == 5));
      chkb($sformatf("to%0d_m0_ready", c), m0_ready, (c == 5 || c == 11));
      chkb($sformatf("to%0d_svalid", c), s_valid, (c >= 1 && c <= 4) || (c >= 7 && c <= 11));
      if (c == 5)  chk("to5_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
      if (c == 11) chk("to11_m0_rdata", m0_rdata, 32'h0BAD_CAFE);
    end

    // Reset during a G1 transfer abandons it; m0 wins first afterwards.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h1111_2222);
    chk("rs_idle_grant", 32'(grant), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h1111_2222);
    chk("rs_g1_grant", 32'(grant), 32'h2);
    #2;
    resetn = 1'b0;
    m0_valid = 1'b1;
    #1;
    $display("reset during G1: grant=%b m1_ready=%b s_valid=%b", grant, m1_ready, s_valid);
    chk("rs_async_grant", 32'(grant), 32'h0);
    chkb("rs_async_svalid", s_valid, 1'b0);
    chkb("rs_async_m1_ready", m1_ready, 1'b0);
    chk("rs_async_m1_rdata", m1_rdata, 32'h0);
    chk("rs_async_saddr", s_addr, 32'h0);
    chk("rs_async_swdata", s_wdata, 32'h0);
    chk("rs_async_swstrb", 32'(s_wstrb), 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rs_after_idle", 32'(grant), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rs_after_first", 32'(grant), 32'h1);

    // Randomized run against the transaction-rule model.
    do_reset();
    owner = 0; waited = 0; last = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        mv[2], mi[2];
      logic [31:0] ma[2], mw[2];
      logic [3:0]  ms[2];
      logic [1:0]  e_grant;
      logic        e_sv, e_si, e_to;
      logic [31:0] e_sa, e_sw;
      logic [3:0]  e_ss;
      logic        e_rdy[2];
      logic [31:0] e_rd[2];
      int k;
      @(negedge clk);
      m0_valid = ($urandom_range(0, 9) < 7); m1_valid = ($urandom_range(0, 9) < 6);
      m0_instr = $urandom_range(0, 1);      m1_instr = $urandom_range(0, 1);
      m0_addr  = $urandom;  m0_wdata = $urandom;  m0_wstrb = 4'($urandom);
      m1_addr  = $urandom;  m1_wdata = $urandom;  m1_wstrb = 4'($urandom);
      s_ready  = ($urandom_range(0, 9) < 3);
      s_rdata  = $urandom;
      #1;
      mv[0] = m0_valid; mv[1] = m1_valid; mi[0] = m0_instr; mi[1] = m1_instr;
      ma[0] = m0_addr;  ma[1] = m1_addr;  mw[0] = m0_wdata; mw[1] = m1_wdata;
      ms[0] = m0_wstrb; ms[1] = m1_wstrb;
      e_grant = 0; e_sv = 0; e_si = 0; e_to = 0; e_sa = 0; e_sw = 0; e_ss = 0;
      e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
      k = owner - 1;
      if (owner != 0) begin
        e_to = (TO != 0) && mv[k] && !s_ready && (waited == TO);
        e_sv = mv[k] && !e_to;
        e_si = mi[k]; e_sa = ma[k]; e_sw = mw[k]; e_ss = ms[k];
        e_grant = (k == 1) ? 2'b10 : 2'b01;
        e_rdy[k] = s_ready || e_to;
        e_rd[k]  = e_to ? 32'hFFFF_FFFF : s_rdata;
      end
      chk("rnd_grant", 32'(grant), 32'(e_grant));
      chkb("rnd_svalid", s_valid, e_sv);
      chkb("rnd_sinstr", s_instr, e_si);
      chk("rnd_saddr", s_addr, e_sa);
      chk("rnd_swdata", s_wdata, e_sw);
      chk("rnd_swstrb", 32'(s_wstrb), 32'(e_ss));
      chkb("rnd_m0_ready", m0_ready, e_rdy[0]);
      chkb("rnd_m1_ready", m1_ready, e_rdy[1]);
      chk("rnd_m0_rdata", m0_rdata, e_rd[0]);
      chk("rnd_m1_rdata", m1_rdata, e_rd[1]);
      chkb("rnd_timeout", timeout_err, e_to);
      // advance model across the coming rising edge
      if (owner == 0) begin
        if (mv[0] || mv[1]) begin
          if (mv[0] && mv[1]) owner = (RR && last == 0) ? 2 : 1;
          else                owner = mv[1] ? 2 : 1;
          waited = 0;
        end
      end else if ((mv[k] && s_ready) || e_to) begin
        $display("txn cycle %0d: master %0d addr %h rdata %h%s", cyc, k, ma[k], e_rd[k],
                 e_to ? " (timeout)" : "");
        last = k;
        owner = 0;
      end else if (!mv[k]) begin
        owner = 0;
      end else if (waited < 65535) begin
        waited++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
